// File: rtl/s38417_onehot_scan.sv
// Registered one-hot channel selector with a sequential scan that counts fields differing from a reference word.
// Define S38417_SEL_CHECK_EN to flag multi-hot selects as errors instead of OR-merging the selected fields.
module s38417_onehot_scan #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int CW  = $clog2(NCH + 1)
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic [NCH-1:0]   sel,
  input  logic [NCH*W-1:0] din,
  input  logic [W-1:0]     ref_word,
  input  logic             start,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    mis_cnt,
  output logic [NCH-1:0]   mis_mask,
  output logic             sel_err
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic [W-1:0]  ref_q;
  logic [W-1:0]  live_field;
  logic [W-1:0]  scan_field;
  logic          sel_any;
  logic          last_ch;

  // Live path is the legacy AND-OR cone; scan path is a plain mux on idx.
  always_comb begin
    live_field = '0;
    scan_field = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel[k]) live_field = live_field | din[k*W +: W];
      if (idx == IW'(k)) scan_field = din[k*W +: W];
    end
  end

  assign sel_any = |sel;
  assign last_ch = (idx == IW'(NCH - 1));

`ifdef S38417_SEL_CHECK_EN
  logic sel_multi;
  assign sel_multi = |(sel & (sel - NCH'(1)));
`endif

  always_ff @(posedge CK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (last_ch) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      mis_cnt   <= '0;
      mis_mask  <= '0;
      idx       <= '0;
      ref_q     <= '0;
`ifdef S38417_SEL_CHECK_EN
      sel_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef S38417_SEL_CHECK_EN
          if (sel_multi) begin
            sel_err   <= 1'b1;
            out_valid <= 1'b0;
          end else if (sel_any) begin
            out_data  <= live_field;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
`else
          if (sel_any) begin
            out_data  <= live_field;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
`endif
          if (start) begin
            idx      <= '0;
            mis_cnt  <= '0;
            mis_mask <= '0;
            ref_q    <= ref_word;
          end
        end
        SCAN: begin
          out_data  <= scan_field;
          out_valid <= 1'b1;
          if (scan_field != ref_q) begin
            mis_mask[idx] <= 1'b1;
            mis_cnt       <= mis_cnt + CW'(1);
          end
          idx <= last_ch ? '0 : idx + IW'(1);
        end
        DONE: out_valid <= 1'b0;
        default: out_valid <= 1'b0;
      endcase
    end
  end

`ifndef S38417_SEL_CHECK_EN
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_s38417_onehot_scan.sv
// Directed self-checking bench for s38417_onehot_scan: a 4x8 instance for most scenarios
// and a 16x1 instance for the wide-count sweep.
module tb_s38417_onehot_scan;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int CW  = $clog2(NCH + 1);

  logic CK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CK = ~CK;

  logic [NCH-1:0]   sel;
  logic [NCH*W-1:0] din;
  logic [W-1:0]     ref_word;
  logic             start;
  logic [W-1:0]     out_data;
  logic             out_valid, busy, done, sel_err;
  logic [CW-1:0]    mis_cnt;
  logic [NCH-1:0]   mis_mask;

  logic [15:0] sel16, din16, mis_mask16;
  logic [0:0]  ref16, out_data16;
  logic        start16, out_valid16, busy16, done16, sel_err16;
  logic [4:0]  mis_cnt16;

  int checks = 0;
  int errors = 0;

  s38417_onehot_scan #(.NCH(NCH), .W(W)) dut (
    .CK(CK), .RST_N(RST_N), .sel(sel), .din(din), .ref_word(ref_word), .start(start),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done),
    .mis_cnt(mis_cnt), .mis_mask(mis_mask), .sel_err(sel_err)
  );

  s38417_onehot_scan #(.NCH(16), .W(1)) dut16 (
    .CK(CK), .RST_N(RST_N), .sel(sel16), .din(din16), .ref_word(ref16), .start(start16),
    .out_data(out_data16), .out_valid(out_valid16), .busy(busy16), .done(done16),
    .mis_cnt(mis_cnt16), .mis_mask(mis_mask16), .sel_err(sel_err16)
  );

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    checks++;
    if ({out_data, out_valid, busy, done, mis_cnt, mis_mask, sel_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {out_data, out_valid, busy, done, mis_cnt, mis_mask, sel_err});
    end
    checks++;
    if ({out_data16, out_valid16, busy16, done16, mis_cnt16, mis_mask16, sel_err16} !== '0) begin
      errors++;
      $display("FAIL reset_outputs16: got %h expected 0",
               {out_data16, out_valid16, busy16, done16, mis_cnt16, mis_mask16, sel_err16});
    end
  endtask

  task automatic test_live_select;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    sel = 4'b0100;
    tick();
    checks++;
    if (out_data !== 8'h33) begin errors++; $display("FAIL live_data: got %h expected 33", out_data); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL live_valid: got %b expected 1", out_valid); end
    sel = 4'b0000;
    tick();
    checks++;
    if (out_data !== 8'h33) begin errors++; $display("FAIL live_hold_data: got %h expected 33", out_data); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL live_hold_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_full_match;
    int busy_cycles, done_at;
    din = {4{8'hA5}};
    ref_word = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    done_at = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (!busy) break;
      busy_cycles++;
      if (done) done_at = cyc;
      if (cyc <= NCH) begin
        checks++;
        if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL match_step%0d: got %h/%b expected a5/1", cyc, out_data, out_valid);
        end
      end
    end
    checks++;
    if (busy_cycles != NCH + 1) begin errors++; $display("FAIL match_busy_len: got %0d expected %0d", busy_cycles, NCH + 1); end
    // done is visible after edge t+NCH, i.e. during cycle t+NCH+1.
    checks++;
    if (done_at != NCH) begin errors++; $display("FAIL match_done_at: got %0d expected %0d", done_at, NCH); end
    checks++;
    if (mis_cnt !== '0 || mis_mask !== '0) begin
      errors++;
      $display("FAIL match_counts: got %0d/%b expected 0/0000", mis_cnt, mis_mask);
    end
  endtask

  task automatic test_partial_mismatch;
    logic [7:0] exp_field [4];
    exp_field = '{8'hA5, 8'hFF, 8'hA5, 8'h00};
    din = {8'h00, 8'hA5, 8'hFF, 8'hA5};
    ref_word = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      tick();
      checks++;
      if (out_data !== exp_field[k]) begin
        errors++;
        $display("FAIL partial_ch%0d: got %h expected %h", k, out_data, exp_field[k]);
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL partial_done: got %b expected 1", done); end
    checks++;
    if (mis_mask !== 4'b1010) begin errors++; $display("FAIL partial_mask: got %b expected 1010", mis_mask); end
    checks++;
    if (mis_cnt !== 3'd2) begin errors++; $display("FAIL partial_cnt: got %0d expected 2", mis_cnt); end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL partial_idle: got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  task automatic test_collision;
    int busy_cycles, done_count;
    din = {8'h04, 8'h03, 8'h02, 8'h01};
    ref_word = 8'h01;
    start = 1'b1;
    tick();
    busy_cycles = busy ? 1 : 0;
    done_count = 0;
    // start stays high through the scan and must be ignored.
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (!busy) break;
      busy_cycles++;
      if (done) done_count++;
    end
    start = 1'b0;
    checks++;
    if (busy_cycles != NCH + 1) begin errors++; $display("FAIL collide_busy_len: got %0d expected %0d", busy_cycles, NCH + 1); end
    checks++;
    if (done_count != 1) begin errors++; $display("FAIL collide_done_count: got %0d expected 1", done_count); end
    checks++;
    if (mis_cnt !== 3'd3 || mis_mask !== 4'b1110) begin
      errors++;
      $display("FAIL collide_counts: got %0d/%b expected 3/1110", mis_cnt, mis_mask);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL collide_no_queue: got busy %b expected 0", busy); end
  endtask

  task automatic test_abort;
    int done_count;
    din = '0;
    ref_word = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (mis_cnt !== 3'd2) begin errors++; $display("FAIL abort_precount: got %0d expected 2", mis_cnt); end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    checks++;
    if ({out_data, out_valid, busy, done, mis_cnt, mis_mask, sel_err} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got %h expected 0",
               {out_data, out_valid, busy, done, mis_cnt, mis_mask, sel_err});
    end
    done_count = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (done || busy) done_count++;
    end
    checks++;
    if (done_count != 0) begin errors++; $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", done_count); end
  endtask

  task automatic test_sweep;
    int done_at;
    din16 = 16'h0000;
    ref16 = 1'b1;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    done_at = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done16) begin
        done_at = cyc;
        break;
      end
    end
    checks++;
    if (done_at != 16) begin errors++; $display("FAIL sweep_done_at: got %0d expected 16", done_at); end
    checks++;
    if (mis_cnt16 !== 5'd16) begin errors++; $display("FAIL sweep_cnt: got %0d expected 16", mis_cnt16); end
    checks++;
    if (mis_mask16 !== 16'hFFFF) begin errors++; $display("FAIL sweep_mask: got %h expected ffff", mis_mask16); end
  endtask

  task automatic test_multi_hot;
    din = {8'h00, 8'h00, 8'hF0, 8'h0F};
    sel = 4'b0001;
    tick();
    checks++;
    if (out_data !== 8'h0F) begin errors++; $display("FAIL multi_pre: got %h expected 0f", out_data); end
    sel = 4'b0011;
    tick();
`ifdef S38417_SEL_CHECK_EN
    checks++;
    if (out_data !== 8'h0F || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL multi_hold: got %h/%b expected 0f/0", out_data, out_valid);
    end
    checks++;
    if (sel_err !== 1'b1) begin errors++; $display("FAIL multi_err: got %b expected 1", sel_err); end
    sel = 4'b0000;
    tick();
    checks++;
    if (sel_err !== 1'b1) begin errors++; $display("FAIL multi_err_sticky: got %b expected 1", sel_err); end
`else
    checks++;
    if (out_data !== 8'hFF || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL multi_or: got %h/%b expected ff/1", out_data, out_valid);
    end
    checks++;
    if (sel_err !== 1'b0) begin errors++; $display("FAIL multi_err: got %b expected 0", sel_err); end
    sel = 4'b0000;
`endif
  endtask

  initial begin
    sel = '0; din = '0; ref_word = '0; start = 1'b0;
    sel16 = '0; din16 = '0; ref16 = '0; start16 = 1'b0;
    test_reset();
    test_live_select();
    test_full_match();
    test_partial_mismatch();
    test_collision();
    test_abort();
    test_sweep();
    test_multi_hot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
